// File: rtl/clock_domain_bridge_rx.sv
// clock_domain_bridge_rx
// Receive (clk_b) side of a toggle req/ack clock-domain bridge. The request
// toggle passes through a flop synchronizer. The data word is captured directly
// because the transmitter holds it stable until the ack returns. Each word is
// presented once on a valid/ready stream. While the one-word slot is full, the
// ack is withheld.
// Optional build macro: CLOCK_DOMAIN_BRIDGE_RX_STATS_EN adds b_word_count and
// b_proto_err.
module clock_domain_bridge_rx #(
  parameter int DATA_WIDTH    = 16,
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 0
) (
  input  logic                  clk_b,
  input  logic                  rst,
  input  logic                  a_req_toggle,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic                  a_ack_toggle,
  output logic [DATA_WIDTH-1:0] b_data,
  output logic                  b_valid,
  input  logic                  b_ready
`ifdef CLOCK_DOMAIN_BRIDGE_RX_STATS_EN
  ,
  output logic [15:0]           b_word_count,
  output logic                  b_proto_err
`endif
);

  localparam int SETTLE_INIT = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOAD   = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_p;
  logic                   req_sync;
  logic                   req_last, req_last_nxt;
  logic                   req_edge;
  logic [3:0]             settle_cnt, settle_cnt_nxt;
  logic                   capture;

  assign req_sync = sync_p[SYNC_STAGES-1];
  assign req_edge = (req_sync != req_last);

  // Request synchronizer: shift the async toggle level through SYNC_STAGES flops
  always_ff @(posedge clk_b) begin
    if (rst) begin
      sync_p <= '0;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], a_req_toggle};
    end
  end

  // Control state: FSM state, last accepted request level, settle counter
  always_ff @(posedge clk_b) begin
    if (rst) begin
      state      <= ST_IDLE;
      req_last   <= 1'b0;
      settle_cnt <= 4'd0;
    end else begin
      state      <= state_nxt;
      req_last   <= req_last_nxt;
      settle_cnt <= settle_cnt_nxt;
    end
  end

  // Next-state logic: detect a new request, optionally settle, then load when the slot is free
  always_comb begin
    state_nxt      = state;
    req_last_nxt   = req_last;
    settle_cnt_nxt = settle_cnt;
    capture        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_edge) begin
          req_last_nxt = req_sync;
          if (SETTLE_CYCLES > 0) begin
            state_nxt      = ST_SETTLE;
            settle_cnt_nxt = 4'(SETTLE_INIT);
          end else begin
            state_nxt = ST_LOAD;
          end
        end
      end
      ST_SETTLE: begin
        if (settle_cnt == 4'd0) begin
          state_nxt = ST_LOAD;
        end else begin
          settle_cnt_nxt = settle_cnt - 4'd1;
        end
      end
      ST_LOAD: begin
        // A word leaving on this edge frees the slot, so capture can overlap the accept
        if (!b_valid || b_ready) begin
          capture   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output slot: capture the held word and toggle the ack, or drain on consumer accept
  always_ff @(posedge clk_b) begin
    if (rst) begin
      b_valid      <= 1'b0;
      b_data       <= '0;
      a_ack_toggle <= 1'b0;
    end else if (capture) begin
      b_valid      <= 1'b1;
      b_data       <= a_data;
      a_ack_toggle <= ~a_ack_toggle;
    end else if (b_valid && b_ready) begin
      b_valid <= 1'b0;
    end
  end

`ifdef CLOCK_DOMAIN_BRIDGE_RX_STATS_EN
  // Statistics: wrapping capture count and sticky flag for request edges seen outside IDLE
  always_ff @(posedge clk_b) begin
    if (rst) begin
      b_word_count <= 16'd0;
      b_proto_err  <= 1'b0;
    end else begin
      if (capture) begin
        b_word_count <= b_word_count + 16'd1;
      end
      if (req_edge && (state != ST_IDLE)) begin
        b_proto_err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_clock_domain_bridge_rx.sv
// Bench for clock_domain_bridge_rx. Expected words go into a queue when they
// are sent. A negedge monitor pops the queue and compares on every accepted word.
module tb_clock_domain_bridge_rx;
  localparam int DW = 16;

  logic          clk_b = 1'b0;
  logic          clk_a = 1'b0;
  logic          rst   = 1'b1;
  logic          a_req = 1'b0;
  logic [DW-1:0] a_data = '0;
  logic          a_ack;
  logic [DW-1:0] b_data;
  logic          b_valid;
  logic          b_ready = 1'b1;

  logic          r5_req = 1'b0;
  logic [DW-1:0] r5_data = '0;
  logic          r5_ack;
  logic [DW-1:0] r5_bdata;
  logic          r5_valid;
  logic          r5_ready = 1'b1;

`ifdef CLOCK_DOMAIN_BRIDGE_RX_STATS_EN
  logic [15:0]   wc, wc5;
  logic          perr, perr5;
`endif

  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_word;
  int            ack_toggles = 0;
  logic          ack_prev = 1'b0;
  logic          s1, s2;
  int            w, guard, t0;

  always #7 clk_b = ~clk_b;
  always #6 clk_a = ~clk_a;

  clock_domain_bridge_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(2), .SETTLE_CYCLES(0)) u_dut (
    .clk_b(clk_b), .rst(rst), .a_req_toggle(a_req), .a_data(a_data),
    .a_ack_toggle(a_ack), .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready)
`ifdef CLOCK_DOMAIN_BRIDGE_RX_STATS_EN
    , .b_word_count(wc), .b_proto_err(perr)
`endif
  );

  clock_domain_bridge_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(3), .SETTLE_CYCLES(3)) u_dut5 (
    .clk_b(clk_b), .rst(rst), .a_req_toggle(r5_req), .a_data(r5_data),
    .a_ack_toggle(r5_ack), .b_data(r5_bdata), .b_valid(r5_valid), .b_ready(r5_ready)
`ifdef CLOCK_DOMAIN_BRIDGE_RX_STATS_EN
    , .b_word_count(wc5), .b_proto_err(perr5)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_b);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    a_req  = 1'b0;
    r5_req = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_ack(input logic val, input string name);
    int k;
    k = 0;
    while (a_ack !== val && k < 60) begin
      tick();
      k++;
    end
    check(name, 32'(a_ack), 32'(val));
  endtask

  // Scoreboard monitor: compare every accepted word against the queue; count ack toggles
  always @(negedge clk_b) begin
    if (!rst && b_valid && b_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: got %h expected no word", b_data);
      end else begin
        exp_word = exp_q.pop_front();
        check("sb_data", 32'(b_data), 32'(exp_word));
      end
    end
    if (a_ack !== ack_prev) ack_toggles++;
    ack_prev = a_ack;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check("rst_valid", 32'(b_valid), 0);
    check("rst_ack", 32'(a_ack), 0);
    check("rst_data", 32'(b_data), 0);
    check("rst_valid5", 32'(r5_valid), 0);
    rst = 1'b0;

    // Single word latency: b_valid/ack on edge 4
    b_ready = 1'b1;
    a_data  = 'h1234;
    exp_q.push_back(16'h1234);
    a_req   = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      check("t1_early_valid", 32'(b_valid), 0);
    end
    tick();
    check("t1_valid_e4", 32'(b_valid), 1);
    check("t1_data_e4", 32'(b_data), 'h1234);
    check("t1_ack_e4", 32'(a_ack), 1);
    tick();
    check("t1_valid_e5", 32'(b_valid), 0);

    // Back-pressure: AAAA held, 5555 stalled, both released without a bubble
    do_reset();
    b_ready = 1'b0;
    a_data  = 'hAAAA;
    exp_q.push_back(16'hAAAA);
    a_req   = ~a_req;
    wait_ack(1'b1, "t2_ack_aaaa");
    a_data  = 'h5555;
    exp_q.push_back(16'h5555);
    a_req   = ~a_req;
    repeat (10) tick();
    check("t2_hold_valid", 32'(b_valid), 1);
    check("t2_hold_data", 32'(b_data), 'hAAAA);
    check("t2_hold_ack", 32'(a_ack), 1);
    b_ready = 1'b1;
    tick();
    check("t2_swap_valid", 32'(b_valid), 1);
    check("t2_swap_data", 32'(b_data), 'h5555);
    check("t2_swap_ack", 32'(a_ack), 0);
    tick();
    check("t2_drain_valid", 32'(b_valid), 0);

    // Free-running clk_a transmitter, 1000 words
    do_reset();
    b_ready = 1'b1;
    t0 = ack_toggles;
    s1 = 1'b0;
    s2 = 1'b0;
    w = 0;
    guard = 0;
    while (w < 1000 && guard < 40000) begin
      @(posedge clk_a);
      guard++;
      s2 = s1;
      s1 = a_ack;
      if (s2 == a_req) begin
        a_data = w[15:0];
        exp_q.push_back(w[15:0]);
        a_req  = ~a_req;
        w++;
      end
    end
    check("t3_words_sent", 32'(w), 1000);
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      tick();
      guard++;
    end
    tick();
    check("t3_drain", 32'(exp_q.size()), 0);
    check("t3_ack_toggles", 32'(ack_toggles - t0), 1000);

    // Reset while stalled in LOAD, then a normal transfer
    do_reset();
    b_ready = 1'b0;
    a_data  = 'h0101;
    exp_q.push_back(16'h0101);
    a_req   = ~a_req;
    wait_ack(1'b1, "t4_ack_first");
    a_data  = 'h0202;
    exp_q.push_back(16'h0202);
    a_req   = ~a_req;
    repeat (8) tick();
    check("t4_stall_ack", 32'(a_ack), 1);
    rst   = 1'b1;
    a_req = 1'b0;
    exp_q.delete();
    tick();
    check("t4_rst_valid", 32'(b_valid), 0);
    check("t4_rst_ack", 32'(a_ack), 0);
    tick();
    rst     = 1'b0;
    b_ready = 1'b1;
    repeat (6) tick();
    check("t4_no_phantom", 32'(b_valid), 0);
    a_data = 'h00FF;
    exp_q.push_back(16'h00FF);
    a_req  = 1'b1;
    wait_ack(1'b1, "t4_ack_00ff");
    tick();
    tick();
    check("t4_drain", 32'(exp_q.size()), 0);

    // SYNC_STAGES=3, SETTLE_CYCLES=3: b_valid rises on edge 8
    do_reset();
    r5_data = 'hBEEF;
    r5_req  = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check("t5_early_valid", 32'(r5_valid), 0);
    end
    tick();
    check("t5_valid_e8", 32'(r5_valid), 1);
    check("t5_data_e8", 32'(r5_bdata), 'hBEEF);
    check("t5_ack_e8", 32'(r5_ack), 1);

`ifdef CLOCK_DOMAIN_BRIDGE_RX_STATS_EN
    // Statistics: capture count and sticky protocol error from a double toggle during stall
    do_reset();
    check("t6_rst_count", 32'(wc), 0);
    b_ready = 1'b0;
    a_data  = 'h1111;
    exp_q.push_back(16'h1111);
    a_req   = ~a_req;
    wait_ack(1'b1, "t6_ack_first");
    a_data  = 'h2222;
    exp_q.push_back(16'h2222);
    a_req   = ~a_req;
    repeat (6) tick();
    a_req   = ~a_req;
    repeat (4) tick();
    a_req   = ~a_req;
    repeat (6) tick();
    check("t6_proto_err", 32'(perr), 1);
    b_ready = 1'b1;
    repeat (12) tick();
    check("t6_count", 32'(wc), 2);
    check("t6_err_sticky", 32'(perr), 1);
    check("t6_drain", 32'(exp_q.size()), 0);
    do_reset();
    check("t6_err_cleared", 32'(perr), 0);
    check("t6_count_cleared", 32'(wc), 0);
`endif

    repeat (4) tick();
    check("final_queue_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
